// File: rtl/s2_pkg.sv
// Shared types and defaults for the S2 serial front end.
package s2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } s2_ser_state_t;

  localparam int   S2_SER_WIDTH_DEFAULT      = 8;
  localparam logic S2_SER_IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/s2_shift_reg.sv
// Loadable WIDTH-bit shift register; ser_out is the next bit to send in either direction.
module s2_shift_reg
  import s2_pkg::*;
#(
  parameter int WIDTH = S2_SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             msb_first,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // The head bit goes straight to x2 at load time, so it is dropped here.
  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = msb_first ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
    else if (shift)
      sr_d = msb_first ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign ser_out = msb_first ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/s2_bit_serializer.sv
// Parallel-to-serial feeder for the S2 FSM with gapless back-to-back words.
// Define S2_SER_PARITY_EN to append an even-parity bit after every word.
module s2_bit_serializer
  import s2_pkg::*;
#(
  parameter int   WIDTH      = S2_SER_WIDTH_DEFAULT,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = S2_SER_IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x2,
  output logic             x2_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  s2_ser_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic          x2_q, x2_valid_q, frame_start_q;
  logic          xfer, head, sr_out, sr_shift;
`ifdef S2_SER_PARITY_EN
  logic          par_q;
`endif

`ifdef S2_SER_PARITY_EN
  assign in_ready = (state_q == IDLE) || (state_q == PAR);
`else
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
`endif

  assign xfer     = in_valid && in_ready;
  assign head     = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign sr_shift = (state_q == SHIFT) && (cnt_q != '0);

  s2_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk       (clk),
    .rst_n     (reset),
    .load      (xfer),
    .load_data (in_data),
    .shift     (sr_shift),
    .msb_first (MSB_FIRST),
    .ser_out   (sr_out)
  );

  // A transfer always (re)starts a frame, whether from IDLE or the last bit slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      x2_q          <= IDLE_LEVEL;
      x2_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef S2_SER_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      if (xfer) begin
        state_q       <= SHIFT;
        cnt_q         <= CNT_LAST;
        x2_q          <= head;
        x2_valid_q    <= 1'b1;
        frame_start_q <= 1'b1;
`ifdef S2_SER_PARITY_EN
        par_q         <= ^in_data;
`endif
      end else begin
        case (state_q)
          SHIFT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
              x2_q  <= sr_out;
            end else begin
`ifdef S2_SER_PARITY_EN
              state_q <= PAR;
              x2_q    <= par_q;
`else
              state_q    <= IDLE;
              x2_q       <= IDLE_LEVEL;
              x2_valid_q <= 1'b0;
`endif
            end
          end
`ifdef S2_SER_PARITY_EN
          PAR: begin
            state_q    <= IDLE;
            x2_q       <= IDLE_LEVEL;
            x2_valid_q <= 1'b0;
          end
`endif
          default: begin
            state_q    <= IDLE;
            x2_q       <= IDLE_LEVEL;
            x2_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x2          = x2_q;
  assign x2_valid    = x2_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_s2_bit_serializer.sv
// Randomized and directed bench for s2_bit_serializer against a bit-queue reference model.
module tb_s2_bit_serializer;
  localparam int W = 8;
`ifdef S2_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = W + PB;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] in_data, l_data;
  logic in_valid, l_valid;
  logic in_ready, x2, x2_valid, frame_start, busy;
  logic l_ready, l_x2, l_x2_valid, l_fs, l_busy;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  s2_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x2(x2), .x2_valid(x2_valid), .frame_start(frame_start), .busy(busy));

  s2_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .reset(rst_n), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .x2(l_x2), .x2_valid(l_x2_valid), .frame_start(l_fs), .busy(l_busy));

  // Reference model: each accepted word becomes a queue of bits to emit, one per cycle.
  bit   mq[$];
  bit   mf[$];
  logic e_x2 = 1'b0, e_vld = 1'b0, e_fs = 1'b0, e_busy = 1'b0, e_rdy = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); mf.delete();
      e_x2 <= 1'b0; e_vld <= 1'b0; e_fs <= 1'b0; e_busy <= 1'b0; e_rdy <= 1'b1;
    end else begin
      if (in_valid && e_rdy) begin
        for (int k = 0; k < W; k++) begin
          mq.push_back(in_data[W-1-k]);
          mf.push_back(k == 0);
        end
        if (PB == 1) begin
          mq.push_back(^in_data);
          mf.push_back(1'b0);
        end
      end
      if (mq.size() != 0) begin
        e_x2   <= mq.pop_front();
        e_fs   <= mf.pop_front();
        e_vld  <= 1'b1;
        e_busy <= 1'b1;
        e_rdy  <= (mq.size() == 0);
      end else begin
        e_x2 <= 1'b0; e_vld <= 1'b0; e_fs <= 1'b0; e_busy <= 1'b0; e_rdy <= 1'b1;
      end
    end
  end

  task automatic test_reset;
    logic [4:0] o, lo;
    in_valid = 1'b1; in_data = 8'hA5; l_valid = 1'b1; l_data = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o  = {x2, x2_valid, frame_start, busy, in_ready};
      lo = {l_x2, l_x2_valid, l_fs, l_busy, l_ready};
      checks++;
      if (o !== 5'b00001) begin failures++; $display("FAIL reset c=%0d got=%b exp=00001", c, o); end
      checks++;
      if (lo !== 5'b10001) begin failures++; $display("FAIL reset_lsb c=%0d got=%b exp=10001", c, lo); end
    end
    in_valid = 1'b0; l_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_idle;
    logic [4:0] o, lo;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_data = W'($urandom); l_data = W'($urandom);
      o  = {x2, x2_valid, frame_start, busy, in_ready};
      lo = {l_x2, l_x2_valid, l_fs, l_busy, l_ready};
      checks++;
      if (o !== 5'b00001) begin failures++; $display("FAIL idle c=%0d got=%b exp=00001", c, o); end
      checks++;
      if (lo !== 5'b10001) begin failures++; $display("FAIL idle_lsb c=%0d got=%b exp=10001", c, lo); end
    end
  endtask

  task automatic test_frame(input logic [W-1:0] w);
    logic [4:0] o, e;
    logic [W-1:0] got;
    logic pbit;
    int nv, nf;
    got = '0; pbit = 1'b0; nv = 0; nf = 0;
    @(negedge clk); in_data = w; in_valid = 1'b1;
    for (int c = 0; c < FL + 3; c++) begin
      @(negedge clk);
      if (c == 0) begin in_valid = 1'b0; in_data = W'($urandom); end
      o = {x2, x2_valid, frame_start, busy, in_ready};
      e = {e_x2, e_vld, e_fs, e_busy, e_rdy};
      checks++;
      if (o !== e) begin failures++; $display("FAIL frame w=%h c=%0d got=%b exp=%b", w, c, o, e); end
      if (c < W) got[W-1-c] = x2;
      if (c == W) pbit = x2;
      nv += int'(x2_valid);
      nf += int'(frame_start);
    end
    checks++;
    if (got !== w) begin failures++; $display("FAIL frame_bits got=%h exp=%h", got, w); end
    checks++;
    if (nv != FL) begin failures++; $display("FAIL frame_len got=%0d exp=%0d", nv, FL); end
    checks++;
    if (nf != 1) begin failures++; $display("FAIL frame_start_cnt got=%0d exp=1", nf); end
`ifdef S2_SER_PARITY_EN
    checks++;
    if (pbit !== ^w) begin failures++; $display("FAIL parity w=%h got=%b exp=%b", w, pbit, ^w); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [4:0] o, e;
    logic [15:0] got;
    logic er;
    int nv;
    got = '0; nv = 0;
    @(negedge clk); in_data = 8'hF0; in_valid = 1'b1;
    for (int c = 0; c < 2*FL + 3; c++) begin
      @(negedge clk);
      if (c == 0) in_data = 8'h0F;
      if (c == FL) in_valid = 1'b0;
      o = {x2, x2_valid, frame_start, busy, in_ready};
      e = {e_x2, e_vld, e_fs, e_busy, e_rdy};
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b c=%0d got=%b exp=%b", c, o, e); end
      er = (c == FL-1) || (c >= 2*FL-1);
      checks++;
      if (in_ready !== er) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, in_ready, er); end
      if (c < 2*FL) begin
        nv += int'(x2_valid);
        if ((c % FL) < W) got = {got[14:0], x2};
      end
    end
    checks++;
    if (got !== 16'hF00F) begin failures++; $display("FAIL b2b_bits got=%h exp=f00f", got); end
    checks++;
    if (nv != 2*FL) begin failures++; $display("FAIL b2b_valid got=%0d exp=%0d", nv, 2*FL); end
  endtask

  task automatic test_lsb_first(input logic [W-1:0] w);
    logic [3:0] o, e;
    @(negedge clk); l_data = w; l_valid = 1'b1;
    for (int c = 0; c < FL + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin l_valid = 1'b0; l_data = ~w; end
      o = {l_x2, l_x2_valid, l_fs, l_busy};
      if (c < W)       e = {w[c], 1'b1, (c == 0), 1'b1};
      else if (c < FL) e = {^w, 1'b1, 1'b0, 1'b1};
      else             e = 4'b1000;
      checks++;
      if (o !== e) begin failures++; $display("FAIL lsb w=%h c=%0d got=%b exp=%b", w, c, o, e); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [4:0] o;
    @(negedge clk); in_data = 8'hFF; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 o = {x2, x2_valid, frame_start, busy, in_ready};
    checks++;
    if (o !== 5'b00001) begin failures++; $display("FAIL midreset_async got=%b exp=00001", o); end
    @(negedge clk);
    o = {x2, x2_valid, frame_start, busy, in_ready};
    checks++;
    if (o !== 5'b00001) begin failures++; $display("FAIL midreset_hold got=%b exp=00001", o); end
    rst_n = 1'b1;
    test_frame(8'h80);
  endtask

  task automatic test_random;
    logic [4:0] o, e;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      o = {x2, x2_valid, frame_start, busy, in_ready};
      e = {e_x2, e_vld, e_fs, e_busy, e_rdy};
      checks++;
      if (o !== e) begin failures++; $display("FAIL random c=%0d got=%b exp=%b", c, o, e); end
      in_valid = (c < 100) && ($urandom_range(2) != 0);
      in_data  = W'($urandom);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; l_valid = 1'b0; l_data = '0;
    test_reset;
    test_idle;
    test_frame(8'hB4);
    test_frame(8'h07);
    test_back_to_back;
    test_lsb_first(8'h01);
    test_lsb_first(W'($urandom));
    test_reset_midframe;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
